// File: rtl/mac_rx_arbiter_pkg.sv
// mac_rx_arbiter_pkg: shared descriptor layout, FSM states and defaults for the mac rx arbiter
package mac_rx_arbiter_pkg;
    localparam int NPORT = 4;
    localparam int DESC_ERR_MSB = 15;
    localparam int DESC_ERR_LSB = 14;
    localparam int DESC_ERR_W = DESC_ERR_MSB - DESC_ERR_LSB + 1;
    localparam int DESC_LEN_W = 11;
    localparam logic [11:0] DATA_HWM_DEF = 12'd2560;
    typedef enum logic [1:0] {IDLE, PTR_RD, PTR_CAP, DATA} state_t;
endpackage

// File: rtl/mac_rx_arbiter_rr_arb4.sv
// rr_arb4: combinational 4-way round-robin pick, first requester at or after the rr pointer
module rr_arb4 (
    input  logic [3:0] req_i,
    input  logic [1:0] rr_i,
    output logic [3:0] gnt_o,
    output logic [1:0] idx_o,
    output logic       any_o
);
    always_comb begin
        idx_o = rr_i;
        any_o = 1'b0;
        for (int i = 3; i >= 0; i--)
            if (req_i[rr_i + 2'(i)]) begin
                idx_o = rr_i + 2'(i);
                any_o = 1'b1;
            end
        gnt_o = any_o ? 4'b0001 << idx_o : 4'b0000;
    end
endmodule

// File: rtl/mac_rx_arbiter.sv
// mac_rx_arbiter: moves whole frames from 4 rx port FIFOs into one ingress FIFO pair, dropping bad frames
module mac_rx_arbiter
    import mac_rx_arbiter_pkg::*;
#(
    parameter logic [11:0] DATA_HWM = DATA_HWM_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NPORT-1:0]   rx_ptr_fifo_empty_i,
    output logic [NPORT-1:0]   rx_ptr_fifo_rd_o,
    input  logic [16*NPORT-1:0] rx_ptr_fifo_din_i,
    output logic [NPORT-1:0]   rx_data_fifo_rd_o,
    input  logic [8*NPORT-1:0] rx_data_fifo_din_i,
    output logic               out_data_fifo_wr_o,
    output logic [7:0]         out_data_fifo_dout_o,
    input  logic [11:0]        out_data_depth_i,
    output logic               out_ptr_fifo_wr_o,
    output logic [15:0]        out_ptr_fifo_dout_o,
    input  logic               out_ptr_fifo_full_i,
    output logic [15:0]        drop_cnt_o
);
    state_t                state_q;
    logic [1:0]            rr_q, g_q, idx;
    logic [NPORT-1:0]      ptr_rd_q, data_rd_q, gnt;
    logic [DESC_LEN_W-1:0] len_q, cnt_q, len;
    logic [DESC_ERR_W-1:0] err;
    logic [15:0]           ptr_dout_q, drop_q, drop_d;
    logic                  good_q, wr_q, ptr_wr_q, any, bp, good;

    rr_arb4 u_arb (
        .req_i(~rx_ptr_fifo_empty_i),
        .rr_i (rr_q),
        .gnt_o(gnt),
        .idx_o(idx),
        .any_o(any)
    );

    assign bp     = out_ptr_fifo_full_i | (out_data_depth_i > DATA_HWM);
    assign err    = rx_ptr_fifo_din_i[{g_q, 4'd0} + 6'(DESC_ERR_LSB) +: DESC_ERR_W];
    assign len    = rx_ptr_fifo_din_i[{g_q, 4'd0} +: DESC_LEN_W];
    assign good   = (err == '0) && (len != '0);
    assign drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            g_q        <= '0;
            ptr_rd_q   <= '0;
            data_rd_q  <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            good_q     <= 1'b0;
            wr_q       <= 1'b0;
            ptr_wr_q   <= 1'b0;
            ptr_dout_q <= '0;
            drop_q     <= '0;
        end else begin
            // data FIFO dout is valid the cycle after rd, so the write trails the read by one
            wr_q     <= (|data_rd_q) & good_q;
            ptr_wr_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (!bp && any) begin
                        g_q      <= idx;
                        ptr_rd_q <= gnt;
                        rr_q     <= idx + 2'd1;
                        state_q  <= PTR_RD;
                    end
                PTR_RD: begin
                    ptr_rd_q <= '0;
                    state_q  <= PTR_CAP;
                end
                PTR_CAP: begin
                    len_q  <= len;
                    cnt_q  <= len;
                    good_q <= good;
                    if (len == '0) begin
                        drop_q  <= drop_d;
                        state_q <= IDLE;
                    end else begin
                        data_rd_q <= 4'b0001 << g_q;
                        state_q   <= DATA;
                    end
                end
                DATA:
                    if (cnt_q > 11'd1) begin
                        cnt_q <= cnt_q - 11'd1;
                    end else begin
                        data_rd_q  <= '0;
                        ptr_wr_q   <= good_q;
                        ptr_dout_q <= {2'b00, g_q, 1'b0, len_q};
                        if (!good_q) drop_q <= drop_d;
                        state_q <= IDLE;
                    end
            endcase
        end
    end

    assign rx_ptr_fifo_rd_o     = ptr_rd_q;
    assign rx_data_fifo_rd_o    = data_rd_q;
    assign out_data_fifo_wr_o   = wr_q;
    assign out_data_fifo_dout_o = rx_data_fifo_din_i[{g_q, 3'd0} +: 8];
    assign out_ptr_fifo_wr_o    = ptr_wr_q;
    assign out_ptr_fifo_dout_o  = ptr_dout_q;
    assign drop_cnt_o           = drop_q;
endmodule

// File: tb/tb_mac_rx_arbiter.sv
// tb_mac_rx_arbiter: scoreboard bench with non-FWFT rx FIFO models and directed frame vectors
module tb_mac_rx_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ptr_empty = 4'hF;
    logic [3:0]  ptr_rd, data_rd;
    logic [63:0] ptr_din = '0;
    logic [31:0] data_din = '0;
    logic        out_wr, out_ptr_wr;
    logic [7:0]  out_dout;
    logic [11:0] depth = '0;
    logic [15:0] out_ptr_dout, drop_cnt;
    logic        ptr_full = 1'b0;

    logic [15:0] ptrq[4][$];
    logic [7:0]  datq[4][$];
    logic [8:0]  exp_data[$];
    logic [15:0] exp_ptr[$];
    int checks = 0, errors = 0;
    int ptr_rd_cnt = 0, data_rd_cnt = 0, wr_cnt = 0, idle_cnt = 0;
    int seq = 0;

    mac_rx_arbiter dut (
        .clk(clk), .rst(rst),
        .rx_ptr_fifo_empty_i(ptr_empty), .rx_ptr_fifo_rd_o(ptr_rd), .rx_ptr_fifo_din_i(ptr_din),
        .rx_data_fifo_rd_o(data_rd), .rx_data_fifo_din_i(data_din),
        .out_data_fifo_wr_o(out_wr), .out_data_fifo_dout_o(out_dout), .out_data_depth_i(depth),
        .out_ptr_fifo_wr_o(out_ptr_wr), .out_ptr_fifo_dout_o(out_ptr_dout), .out_ptr_fifo_full_i(ptr_full),
        .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    // non-FWFT rx FIFOs: a read strobe seen at an edge presents the next entry after that edge
    always @(posedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (ptr_rd[p] && ptrq[p].size() > 0) ptr_din[16*p +: 16] <= ptrq[p].pop_front();
            if (data_rd[p] && datq[p].size() > 0) data_din[8*p +: 8] <= datq[p].pop_front();
            ptr_empty[p] <= (ptrq[p].size() == 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_wr) begin
                checks++;
                if (exp_data.size() == 0) begin
                    errors++;
                    $display("FAIL data_extra: got byte %h last %b, expected no write", out_dout, out_ptr_wr);
                end else if ({out_ptr_wr, out_dout} != exp_data[0]) begin
                    errors++;
                    $display("FAIL data_byte: got last %b byte %h, expected last %b byte %h",
                             out_ptr_wr, out_dout, exp_data[0][8], exp_data[0][7:0]);
                    void'(exp_data.pop_front());
                end else void'(exp_data.pop_front());
            end
            if (out_ptr_wr) begin
                checks++;
                if (!out_wr) begin
                    errors++;
                    $display("FAIL ptr_align: ptr write %h without data write", out_ptr_dout);
                end
                if (exp_ptr.size() == 0) begin
                    errors++;
                    $display("FAIL ptr_extra: got %h, expected no write", out_ptr_dout);
                end else begin
                    if (out_ptr_dout != exp_ptr[0]) begin
                        errors++;
                        $display("FAIL ptr_word: got %h, expected %h", out_ptr_dout, exp_ptr[0]);
                    end
                    void'(exp_ptr.pop_front());
                end
            end
            if (ptr_rd != 0 || data_rd != 0) begin
                checks++;
                if ($countones({ptr_rd, data_rd}) > 1) begin
                    errors++;
                    $display("FAIL onehot: ptr_rd %b data_rd %b, expected at most one strobe", ptr_rd, data_rd);
                end
            end
            if (ptr_rd != 0) ptr_rd_cnt++;
            if (data_rd != 0) data_rd_cnt++;
            if (out_wr) wr_cnt++;
            if (ptr_rd == 0 && data_rd == 0 && !out_wr && !out_ptr_wr) idle_cnt++;
            else idle_cnt = 0;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic load_frame(input int p, input logic [1:0] err, input int len);
        logic [7:0] b;
        logic good;
        good = (err == 2'b00) && (len != 0);
        ptrq[p].push_back({err, 3'b000, 11'(len)});
        for (int i = 0; i < len; i++) begin
            b = 8'((p << 6) ^ (i * 3) ^ (seq * 17));
            datq[p].push_back(b);
            if (good) exp_data.push_back({i == len - 1, b});
        end
        if (good) exp_ptr.push_back({2'b00, 2'(p), 1'b0, 11'(len)});
        seq++;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(exp_data.size() == 0 && exp_ptr.size() == 0 && ptrq[0].size() == 0 &&
                 ptrq[1].size() == 0 && ptrq[2].size() == 0 && ptrq[3].size() == 0 &&
                 idle_cnt >= 4) && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL %s_timeout: frames still pending after %0d cycles, expected completion", name, n);
        end
    endtask

    initial begin
        int d0, w0, p0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_ptr_rd", int'(ptr_rd), 0);
        chk("rst_data_rd", int'(data_rd), 0);
        chk("rst_out_wr", int'({out_wr, out_ptr_wr}), 0);
        chk("rst_ptr_dout", int'(out_ptr_dout), 0);
        chk("rst_drop", int'(drop_cnt), 0);

        for (int k = 0; k < 2; k++) begin
            load_frame(0, 2'b00, 5 + k);
            load_frame(1, 2'b00, 3 + k);
            load_frame(3, 2'b00, 7 - k);
        end
        wait_done("rr_order");

        w0 = wr_cnt;
        load_frame(2, 2'b00, 64);
        wait_done("port2_len64");
        chk("port2_wr_cnt", wr_cnt - w0, 64);

        d0 = data_rd_cnt; w0 = wr_cnt;
        load_frame(1, 2'b01, 100);
        wait_done("bad_frame");
        chk("bad_drain_cnt", data_rd_cnt - d0, 100);
        chk("bad_wr_cnt", wr_cnt - w0, 0);
        chk("bad_drop", int'(drop_cnt), 1);

        ptr_full = 1'b1;
        p0 = ptr_rd_cnt;
        load_frame(2, 2'b00, 10);
        repeat (20) @(negedge clk);
        #1;
        chk("bp_full_no_grant", ptr_rd_cnt - p0, 0);
        ptr_full = 1'b0;
        wait_done("bp_full_release");
        depth = 12'd2561;
        p0 = ptr_rd_cnt;
        load_frame(3, 2'b00, 12);
        repeat (20) @(negedge clk);
        #1;
        chk("bp_depth_no_grant", ptr_rd_cnt - p0, 0);
        depth = 12'd2560;
        wait_done("bp_depth_hwm");
        depth = 12'd0;

        d0 = data_rd_cnt; w0 = wr_cnt;
        load_frame(0, 2'b00, 0);
        wait_done("len0");
        chk("len0_data_rd", data_rd_cnt - d0, 0);
        chk("len0_wr", wr_cnt - w0, 0);
        chk("len0_drop", int'(drop_cnt), 2);
        load_frame(0, 2'b00, 1);
        wait_done("len1");

        load_frame(0, 2'b00, 40);
        begin
            int n = 0;
            while (data_rd == 0 && n < 100) begin @(negedge clk); #1; n++; end
            chk("rst_mid_reached_data", int'(data_rd), 1);
        end
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        for (int p = 0; p < 4; p++) begin ptrq[p].delete(); datq[p].delete(); end
        exp_data.delete();
        exp_ptr.delete();
        @(negedge clk); #1;
        chk("rst_mid_ptr_rd", int'(ptr_rd), 0);
        chk("rst_mid_data_rd", int'(data_rd), 0);
        chk("rst_mid_wr", int'({out_wr, out_ptr_wr}), 0);
        chk("rst_mid_drop", int'(drop_cnt), 0);
        rst = 1'b0;
        load_frame(0, 2'b00, 9);
        load_frame(1, 2'b00, 6);
        wait_done("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
